// File: rtl/fp_issue_ctrl.sv
// FP issue controller: latches the arbiter-granted request, issues it to the shared FPU,
// and routes the result back. Optional WAIT watchdog enabled by FP_ISSUE_TIMEOUT_EN.
module fp_issue_ctrl #(
    parameter int DATA_W      = 32,
    parameter int OP_W        = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          req,
    input  logic [4*OP_W-1:0]   req_op,
    input  logic [4*DATA_W-1:0] req_a,
    input  logic [4*DATA_W-1:0] req_b,
    input  logic [3:0]          arb_gnt,
    output logic                busy,
    output logic                fpu_valid,
    input  logic                fpu_ready,
    output logic [OP_W-1:0]     fpu_op,
    output logic [DATA_W-1:0]   fpu_a,
    output logic [DATA_W-1:0]   fpu_b,
    output logic [1:0]          fpu_tag,
    input  logic                fpu_done,
    input  logic [DATA_W-1:0]   fpu_result,
    output logic [3:0]          resp_valid,
    output logic [DATA_W-1:0]   resp_data,
    output logic                resp_err
);
    // state | meaning
    // IDLE  | waiting for a granted, requesting port
    // ISSUE | fpu_valid high, waiting for fpu_ready
    // WAIT  | op accepted by FPU, waiting for fpu_done (or timeout)
    // RESP  | one-cycle resp_valid pulse to the latched requester
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]        state;
    logic              gnt_onehot;
    logic              accept;
    logic              timeout;
    logic [1:0]        gnt_idx;
    logic [OP_W-1:0]   sel_op;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;

    assign gnt_onehot = (arb_gnt != 4'b0000) && ((arb_gnt & (arb_gnt - 4'd1)) == 4'b0000);
    assign accept     = gnt_onehot && (|(req & arb_gnt));

    always_comb begin
        gnt_idx = 2'd0;
        sel_op  = '0;
        sel_a   = '0;
        sel_b   = '0;
        for (int i = 0; i < 4; i++) begin
            if (arb_gnt[i]) begin
                gnt_idx = 2'(i);
                sel_op  = req_op[i*OP_W +: OP_W];
                sel_a   = req_a[i*DATA_W +: DATA_W];
                sel_b   = req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    assign busy      = (state != IDLE);
    assign fpu_valid = (state == ISSUE);

    always_comb begin
        resp_valid = 4'b0000;
        if (state == RESP) resp_valid[fpu_tag] = 1'b1;
    end

`ifdef FP_ISSUE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_nxt;
    logic             resp_err_q;

    // Expiry is judged on the incremented count so RESP lands TIMEOUT_CYC cycles after WAIT entry.
    assign wait_cnt_nxt = wait_cnt + CNT_W'(1);
    assign timeout      = (state == WAIT) && !fpu_done && (wait_cnt_nxt == TO_VAL);
    assign resp_err     = resp_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt   <= '0;
            resp_err_q <= 1'b0;
        end else begin
            if (state == ISSUE) wait_cnt <= '0;
            else if (state == WAIT) wait_cnt <= wait_cnt_nxt;
            if (state == WAIT && fpu_done) resp_err_q <= 1'b0;
            else if (timeout) resp_err_q <= 1'b1;
        end
    end
`else
    assign timeout  = 1'b0;
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            fpu_op    <= '0;
            fpu_a     <= '0;
            fpu_b     <= '0;
            fpu_tag   <= 2'd0;
            resp_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        fpu_tag <= gnt_idx;
                        fpu_op  <= sel_op;
                        fpu_a   <= sel_a;
                        fpu_b   <= sel_b;
                        state   <= ISSUE;
                    end
                end
                ISSUE: if (fpu_ready) state <= WAIT;
                WAIT: begin
                    if (fpu_done) begin
                        resp_data <= fpu_result;
                        state     <= RESP;
                    end else if (timeout) begin
                        resp_data <= '0;
                        state     <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Directed self-checking bench for fp_issue_ctrl; the timeout scenario runs only when
// FP_ISSUE_TIMEOUT_EN is defined for both bench and RTL.
module tb_fp_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [15:0] req_op = '0;
    logic [127:0] req_a = '0;
    logic [127:0] req_b = '0;
    logic [3:0]  arb_gnt = '0;
    logic        busy;
    logic        fpu_valid;
    logic        fpu_ready = 1'b0;
    logic [3:0]  fpu_op;
    logic [31:0] fpu_a;
    logic [31:0] fpu_b;
    logic [1:0]  fpu_tag;
    logic        fpu_done = 1'b0;
    logic [31:0] fpu_result = '0;
    logic [3:0]  resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;

    int pass_cnt = 0;
    int total    = 0;

    fp_issue_ctrl #(.DATA_W(32), .OP_W(4), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .arb_gnt(arb_gnt), .busy(busy), .fpu_valid(fpu_valid), .fpu_ready(fpu_ready),
        .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_tag(fpu_tag),
        .fpu_done(fpu_done), .fpu_result(fpu_result), .resp_valid(resp_valid),
        .resp_data(resp_data), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({busy, fpu_valid, fpu_op, fpu_a, fpu_b, fpu_tag, resp_valid, resp_data, resp_err} !== '0)
            $display("FAIL reset_outputs: got busy=%b vld=%b op=%h a=%h b=%h tag=%h rv=%b rd=%h err=%b, need all 0",
                     busy, fpu_valid, fpu_op, fpu_a, fpu_b, fpu_tag, resp_valid, resp_data, resp_err);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_op();
        req = 4'b0010; arb_gnt = 4'b0010; fpu_ready = 1'b1;
        req_op[7:4] = 4'd3; req_a[63:32] = 32'h3F80_0000; req_b[63:32] = 32'h4000_0000;
        tick();
        total++;
        if ({busy, fpu_valid, fpu_tag, fpu_op} !== {1'b1, 1'b1, 2'd1, 4'd3})
            $display("FAIL basic_issue: got busy=%b vld=%b tag=%0d op=%0d, need 1 1 1 3", busy, fpu_valid, fpu_tag, fpu_op);
        else pass_cnt++;
        total++;
        if ({fpu_a, fpu_b} !== {32'h3F80_0000, 32'h4000_0000})
            $display("FAIL basic_operands: got a=%h b=%h, need 3f800000 40000000", fpu_a, fpu_b);
        else pass_cnt++;
        tick();
        total++;
        if ({busy, fpu_valid, resp_valid} !== {1'b1, 1'b0, 4'b0000})
            $display("FAIL basic_wait: got busy=%b vld=%b rv=%b, need 1 0 0000", busy, fpu_valid, resp_valid);
        else pass_cnt++;
        tick();
        fpu_done = 1'b1; fpu_result = 32'h4040_0000;
        tick();
        fpu_done = 1'b0;
        total++;
        if ({busy, resp_valid, resp_data, resp_err} !== {1'b1, 4'b0010, 32'h4040_0000, 1'b0})
            $display("FAIL basic_resp: got busy=%b rv=%b rd=%h err=%b, need 1 0010 40400000 0", busy, resp_valid, resp_data, resp_err);
        else pass_cnt++;
        req = 4'b0000; arb_gnt = 4'b0001;
        tick();
        total++;
        if ({busy, resp_valid, resp_data} !== {1'b0, 4'b0000, 32'h4040_0000})
            $display("FAIL basic_after: got busy=%b rv=%b rd=%h, need 0 0000 40400000", busy, resp_valid, resp_data);
        else pass_cnt++;
    endtask

    task automatic test_default_grant();
        req = 4'b0000; arb_gnt = 4'b1000; fpu_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            fpu_done = 1'b0;
            total++;
            if ({busy, fpu_valid, resp_valid} !== {1'b0, 1'b0, 4'b0000})
                $display("FAIL default_grant_%0d: got busy=%b vld=%b rv=%b, need 0 0 0000", i, busy, fpu_valid, resp_valid);
            else pass_cnt++;
        end
        req = 4'b0011; arb_gnt = 4'b0011;
        tick();
        total++;
        if (busy !== 1'b0)
            $display("FAIL multi_hot_grant: got busy=%b, need 0", busy);
        else pass_cnt++;
        req = 4'b0000; arb_gnt = 4'b0000;
    endtask

    task automatic test_ready_stall();
        int vcnt = 0;
        fpu_ready = 1'b0;
        req = 4'b0001; arb_gnt = 4'b0001;
        req_op[3:0] = 4'd5; req_a[31:0] = 32'h1111_2222; req_b[31:0] = 32'h3333_4444;
        tick();
        req_a[31:0] = 32'hDEAD_BEEF; req_op[3:0] = 4'd9;
        for (int i = 0; i < 6; i++) begin
            if (fpu_valid === 1'b1) vcnt++;
            total++;
            if ({fpu_op, fpu_a, fpu_b} !== {4'd5, 32'h1111_2222, 32'h3333_4444})
                $display("FAIL stall_stable_%0d: got op=%0d a=%h b=%h, need 5 11112222 33334444", i, fpu_op, fpu_a, fpu_b);
            else pass_cnt++;
            if (i == 5) fpu_ready = 1'b1;
            tick();
        end
        total++;
        if ({vcnt, fpu_valid} !== {32'd6, 1'b0})
            $display("FAIL stall_valid_len: got cycles=%0d vld_after=%b, need 6 0", vcnt, fpu_valid);
        else pass_cnt++;
        fpu_done = 1'b1; fpu_result = 32'h5555_AAAA;
        tick();
        fpu_done = 1'b0;
        total++;
        if ({resp_valid, resp_data} !== {4'b0001, 32'h5555_AAAA})
            $display("FAIL stall_resp: got rv=%b rd=%h, need 0001 5555aaaa", resp_valid, resp_data);
        else pass_cnt++;
        req = 4'b0000; arb_gnt = 4'b0000;
        tick();
    endtask

    task automatic test_back_to_back();
        req = 4'b1001; arb_gnt = 4'b0001; fpu_ready = 1'b1;
        req_a[127:96] = 32'h0000_0077;
        tick();
        tick();
        fpu_done = 1'b1; fpu_result = 32'h0000_0A0A;
        tick();
        fpu_done = 1'b0;
        total++;
        if ({resp_valid, resp_data} !== {4'b0001, 32'h0000_0A0A})
            $display("FAIL b2b_first: got rv=%b rd=%h, need 0001 00000a0a", resp_valid, resp_data);
        else pass_cnt++;
        req = 4'b1000; arb_gnt = 4'b1000;
        tick();
        total++;
        if ({busy, resp_valid} !== {1'b0, 4'b0000})
            $display("FAIL b2b_idle_gap: got busy=%b rv=%b, need 0 0000", busy, resp_valid);
        else pass_cnt++;
        tick();
        total++;
        if ({fpu_valid, fpu_tag, fpu_a} !== {1'b1, 2'd3, 32'h0000_0077})
            $display("FAIL b2b_second_issue: got vld=%b tag=%0d a=%h, need 1 3 00000077", fpu_valid, fpu_tag, fpu_a);
        else pass_cnt++;
        tick();
        fpu_done = 1'b1; fpu_result = 32'h0000_0B0B;
        tick();
        fpu_done = 1'b0;
        total++;
        if ({resp_valid, resp_data} !== {4'b1000, 32'h0000_0B0B})
            $display("FAIL b2b_second: got rv=%b rd=%h, need 1000 00000b0b", resp_valid, resp_data);
        else pass_cnt++;
        req = 4'b0000; arb_gnt = 4'b0000;
        tick();
    endtask

`ifdef FP_ISSUE_TIMEOUT_EN
    task automatic test_timeout();
        req = 4'b0010; arb_gnt = 4'b0010; fpu_ready = 1'b1;
        tick();
        tick();
        for (int i = 1; i < 8; i++) begin
            tick();
            total++;
            if ({busy, resp_valid} !== {1'b1, 4'b0000})
                $display("FAIL timeout_early_%0d: got busy=%b rv=%b, need 1 0000", i, busy, resp_valid);
            else pass_cnt++;
        end
        tick();
        total++;
        if ({resp_valid, resp_err, resp_data} !== {4'b0010, 1'b1, 32'h0})
            $display("FAIL timeout_resp: got rv=%b err=%b rd=%h, need 0010 1 00000000", resp_valid, resp_err, resp_data);
        else pass_cnt++;
        req = 4'b0000; arb_gnt = 4'b0000;
        tick();
    endtask
`endif

    task automatic test_reset_mid_op();
        req = 4'b0100; arb_gnt = 4'b0100; fpu_ready = 1'b1;
        req_op[11:8] = 4'd7; req_a[95:64] = 32'hCAFE_0001; req_b[95:64] = 32'hCAFE_0002;
        tick();
        tick();
        total++;
        if ({busy, fpu_tag} !== {1'b1, 2'd2})
            $display("FAIL rst_pre_wait: got busy=%b tag=%0d, need 1 2", busy, fpu_tag);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({busy, fpu_valid, fpu_op, fpu_a, fpu_b, fpu_tag, resp_valid, resp_data, resp_err} !== '0)
            $display("FAIL rst_mid_op: got busy=%b vld=%b op=%h a=%h b=%h tag=%h rv=%b rd=%h err=%b, need all 0",
                     busy, fpu_valid, fpu_op, fpu_a, fpu_b, fpu_tag, resp_valid, resp_data, resp_err);
        else pass_cnt++;
        req = 4'b0000; arb_gnt = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        fpu_done = 1'b1; fpu_result = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            tick();
            fpu_done = 1'b0;
            total++;
            if ({busy, resp_valid, resp_data} !== {1'b0, 4'b0000, 32'h0})
                $display("FAIL rst_late_done_%0d: got busy=%b rv=%b rd=%h, need 0 0000 00000000", i, busy, resp_valid, resp_data);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_basic_op();
        test_default_grant();
        test_ready_stall();
        test_back_to_back();
`ifdef FP_ISSUE_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_op();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
